wm8731_i2c_config: RTL and testbench

//   I2C write sequencer that configures the DE2-115 onboard WM8731 codec for
//   the I2S audio output path: 16-bit I2S slave, DAC to line/headphone out.
//   It sits beside the i2s_audio_out stage and drives I2C_SCLK / I2C_SDAT.
//   It replaces the vendor I2C config core when INSTANTIATE_SOUND_OUTPUT_INTERFACE_MODULE is set.

---
 rtl/wm8731_i2c_config.sv | 208 ++++++++++++++++++++
 tb/tb_wm8731_i2c_config.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_i2c_config.sv
// wm8731_i2c_config: I2C write sequencer for the DE2-115 WM8731 codec.
// Writes 11 register words (I2S 16b slave, DAC out) over open-drain SDA.
module wm8731_i2c_config #(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned i2c_khz  = 100,
  parameter logic [6:0]  dev_addr = 7'h1A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] word_idx
);

  localparam int unsigned QDIV =
    (clk_mhz * 1000) / (4 * i2c_khz);
  localparam int unsigned CW =
    (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);
  localparam logic [3:0] LAST_W = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    qtr_q;
  logic [3:0]    bit_q;
  logic [1:0]    byte_q;
  logic [23:0]   sh_q;
  logic [23:0]   frame_d;
  logic [3:0]    word_q;
  logic          nack_q;
  logic          boot_q;
  logic          scl_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          tick;

  function automatic logic [15:0] word_rom(
    input logic [3:0] i
  );
    logic [15:0] w;
    case (i)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h0017;
      4'd2:    w = 16'h0217;
      4'd3:    w = 16'h0479;
      4'd4:    w = 16'h0679;
      4'd5:    w = 16'h0812;
      4'd6:    w = 16'h0A00;
      4'd7:    w = 16'h0C00;
      4'd8:    w = 16'h0E02;
      4'd9:    w = 16'h1000;
      4'd10:   w = 16'h1201;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign tick    = (cnt_q == QLAST);
  assign cnt_d   = (state_q == S_IDLE || tick)
                 ? '0 : cnt_q + 1'b1;
  assign frame_d = {dev_addr, 1'b0, word_rom(word_q)};

  // Sequencer: one quarter-period step per tick, bus pins registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 4'd0;
      byte_q   <= 2'd0;
      sh_q     <= '0;
      word_q   <= 4'd0;
      nack_q   <= 1'b0;
      boot_q   <= 1'b1;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      boot_q <= 1'b0;
      cnt_q  <= cnt_d;
      unique case (state_q)
        S_IDLE: begin
          if (start || boot_q) begin
            state_q  <= S_START;
            qtr_q    <= 2'd0;
            word_q   <= 4'd0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd1) begin
              sda_oe_q <= 1'b1;
            end
            if (qtr_q == 2'd3) begin
              state_q  <= S_BIT;
              bit_q    <= 4'd0;
              byte_q   <= 2'd0;
              nack_q   <= 1'b0;
              sh_q     <= frame_d;
              scl_q    <= 1'b0;
              sda_oe_q <= ~frame_d[23];
            end
          end
        end
        S_BIT: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd1: scl_q <= 1'b1;
              2'd2: begin
                if (bit_q == 4'd8) begin
                  nack_q <= i2c_sda;
                end
              end
              2'd3: begin
                scl_q <= 1'b0;
                if (bit_q != 4'd8) begin
                  sh_q     <= {sh_q[22:0], 1'b0};
                  bit_q    <= bit_q + 4'd1;
                  sda_oe_q <= (bit_q == 4'd7)
                            ? 1'b0 : ~sh_q[22];
                end else if (nack_q ||
                             byte_q == 2'd2) begin
                  state_q  <= S_STOP;
                  sda_oe_q <= 1'b1;
                end else begin
                  bit_q    <= 4'd0;
                  byte_q   <= byte_q + 2'd1;
                  sda_oe_q <= ~sh_q[23];
                end
              end
              default: begin
              end
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd0) begin
              scl_q <= 1'b1;
            end
            if (qtr_q == 2'd1) begin
              sda_oe_q <= 1'b0;
            end
            if (qtr_q == 2'd3) begin
              if (nack_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                error_q <= 1'b1;
              end else begin
                state_q <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              if (word_q == LAST_W) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_START;
                word_q  <= word_q + 4'd1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i2c_scl  = scl_q;
  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign word_idx = word_q;

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// tb_wm8731_i2c_config: randomized bench with an I2C slave/decoder model.
// Decoded bus bytes and status are compared against the codec word table.
module tb_wm8731_i2c_config;

  localparam int QD      = 3;
  localparam int WQ      = 120;
  localparam int SEQ_CYC = 11 * WQ * QD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       scl;
  wire        sda;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] word_idx;
  logic       slv_pull = 1'b0;

  assign sda = slv_pull ? 1'b0 : 1'bz;
  pullup (sda);

  wm8731_i2c_config #(
    .clk_mhz (3),
    .i2c_khz (250),
    .dev_addr(7'h1A)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [0:10] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479,
    16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
    16'h0E02, 16'h1000, 16'h1201
  };

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got_v, exp_v);
    end
  endtask

  int         cyc = 0;
  int         starts = 0;
  int         stops = 0;
  int         bad_per = 0;
  int         bitn = 0;
  int         nbyte = 0;
  int         last_rise = 0;
  logic [7:0] sb = '0;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         nack_en = 1'b0;
  int         nack_w = 0;
  int         nack_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic s_scl;
    logic s_sda;
    s_scl = scl;
    s_sda = sda;
    if (pscl && s_scl && psda && !s_sda) begin
      starts++;
      bitn  = 0;
      nbyte = 0;
      slv_pull = 1'b0;
    end else if (pscl && s_scl && !psda && s_sda) begin
      stops++;
    end else if (!pscl && s_scl) begin
      if (bitn > 0 && bitn <= 8 &&
          (cyc - last_rise) != 4 * QD)
        bad_per++;
      last_rise = cyc;
      if (bitn < 8) begin
        sb = {sb[6:0], s_sda};
        bitn++;
        if (bitn == 8) got_q.push_back(sb);
      end else begin
        bitn = 9;
      end
    end else if (pscl && !s_scl) begin
      if (bitn == 8) begin
        slv_pull = !(nack_en && (starts - 1) == nack_w &&
                     nbyte == nack_b);
      end else if (bitn == 9) begin
        slv_pull = 1'b0;
        bitn = 0;
        nbyte++;
      end
    end
    pscl = s_scl;
    psda = s_sda;
  end

  task automatic clear_mon();
    starts  = 0;
    stops   = 0;
    bad_per = 0;
    got_q.delete();
  endtask

  task automatic build_exp(input int last_w, input int last_b);
    logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i <= last_w; i++) begin
      w = tbl[i];
      for (int b = 0; b < 3; b++) begin
        if (i < last_w || b <= last_b) begin
          if (b == 0)      exp_q.push_back(8'h34);
          else if (b == 1) exp_q.push_back(w[15:8]);
          else             exp_q.push_back(w[7:0]);
        end
      end
    end
  endtask

  task automatic wait_end(input int pulse_at, output int n);
    n = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_done", done, 0);
    chk("e0_error", error, 0);
    chk("e0_idx", word_idx, 0);
    while (busy && n < SEQ_CYC + 20) begin
      @(posedge clk);
      n++;
      #1;
      start = (n == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag,
                           input int last_w, input int last_b,
                           input int n, input int exp_n,
                           input logic exp_err);
    int nbad;
    build_exp(last_w, last_b);
    chk({tag, "_cycles"}, n, exp_n);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    nbad = 0;
    foreach (exp_q[i])
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes_bad"}, nbad, 0);
    chk({tag, "_starts"}, starts, last_w + 1);
    chk({tag, "_stops"}, stops, last_w + 1);
    chk({tag, "_scl_period"}, bad_per, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_idx"}, word_idx, last_w);
  endtask

  function automatic int abort_cyc(input int w, input int b);
    return (w * WQ + 8 + 36 * (b + 1)) * QD;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int found;
    int w;
    int b;

    repeat (4) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_idx", word_idx, 0);

    clear_mon();
    rst_n = 1'b1;
    wait_end(-1, n);
    check_run("t1", 10, 2, n, SEQ_CYC, 1'b0);
    chk("t1_first0", got_q[0], 8'h34);
    chk("t1_first1", got_q[1], 8'h1E);
    chk("t1_first2", got_q[2], 8'h00);
    chk("t1_last0", got_q[30], 8'h34);
    chk("t1_last1", got_q[31], 8'h12);
    chk("t1_last2", got_q[32], 8'h01);
    chk("t1_idle_sda", sda, 1);
    chk("t1_idle_scl", scl, 1);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    k = $urandom_range(100, SEQ_CYC - 100);
    wait_end(k, n);
    check_run("t3", 10, 2, n, SEQ_CYC, 1'b0);

    nack_en = 1'b1;
    nack_w  = 3;
    nack_b  = 1;
    @(negedge clk);
    clear_mon();
    start = 1'b1;
    wait_end(-1, n);
    check_run("t2", 3, 1, n, abort_cyc(3, 1), 1'b1);
    repeat (2 * WQ * QD) @(posedge clk);
    #1;
    chk("t2_no_restart", starts, 4);
    chk("t2_bus_scl", scl, 1);
    chk("t2_bus_sda", sda, 1);

    nack_en = 1'b0;
    @(negedge clk);
    clear_mon();
    start = 1'b1;
    wait_end(-1, n);
    check_run("t4", 10, 2, n, SEQ_CYC, 1'b0);

    w = $urandom_range(0, 10);
    b = $urandom_range(0, 2);
    nack_en = 1'b1;
    nack_w  = w;
    nack_b  = b;
    @(negedge clk);
    clear_mon();
    start = 1'b1;
    wait_end(-1, n);
    check_run("t2r", w, b, n, abort_cyc(w, b), 1'b1);

    nack_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = $urandom_range(50, SEQ_CYC - 600);
    repeat (k) @(posedge clk);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (scl == 1'b0 && sda == 1'b0 && !slv_pull &&
          bitn >= 1 && bitn <= 7)
        found = 1;
    end
    chk("t5_found", found, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_scl", scl, 1);
    chk("t5_sda", sda, 1);
    chk("t5_busy", busy, 0);
    chk("t5_error", error, 0);
    repeat (3) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    wait_end(-1, n);
    check_run("t5", 10, 2, n, SEQ_CYC, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
